feistel_round_engine: RTL and testbench

Multi-round DES Feistel datapath, the parametrised successor to the single-round feistel_function. Iterates NUM_ROUNDS Feistel rounds on a 64-bit block that has already been through the initial permutation. ROUNDS_PER_CYCLE unrolled feistel_function instances run per clock. Has encrypt/decrypt key ordering, valid/ready handshakes on both sides, and an external round-key lookup port. Sits between the IP/FP wrappers and the key schedule in the DES core.

---
 rtl/feistel_round_engine_if.sv | 35 +++
 rtl/feistel_round_engine.sv | 146 ++++++++++++++
 tb/tb_feistel_round_engine.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/feistel_round_engine_if.sv
// Block/key bus of the Feistel round engine: input and output valid/ready, key lookup.
// With FEISTEL_ABORT_EN defined the bus also carries an abort strobe towards the engine.
interface feistel_round_engine_if #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int IDX_W            = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic [63:0]                    in_block;
  logic                           in_decrypt;
  logic [IDX_W-1:0]               key_idx;
  logic [48*ROUNDS_PER_CYCLE-1:0] round_keys;
  logic                           out_valid;
  logic                           out_ready;
  logic [63:0]                    out_block;
`ifdef FEISTEL_ABORT_EN
  logic                           abort;
`endif

  modport slave (
    input  in_valid, in_block, in_decrypt, round_keys, out_ready,
`ifdef FEISTEL_ABORT_EN
    input  abort,
`endif
    output in_ready, key_idx, out_valid, out_block
  );

  modport master (
    output in_valid, in_block, in_decrypt, round_keys, out_ready,
`ifdef FEISTEL_ABORT_EN
    output abort,
`endif
    input  in_ready, key_idx, out_valid, out_block
  );
endinterface

// File: rtl/feistel_round_engine.sv
// Multi-round DES Feistel datapath, ROUNDS_PER_CYCLE unrolled rounds per clock.
// Define FEISTEL_ABORT_EN to let bus.abort drop the block in flight.
//
// state  | meaning
// S_IDLE | waiting for a block, in_ready high
// S_RUN  | applying one group of rounds per cycle, key_idx live
// S_DONE | result held on out_block with out_valid high
module feistel_round_engine #(
  parameter int NUM_ROUNDS       = 16,
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int IDX_W            = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  feistel_round_engine_if.slave bus
);
  localparam int NUM_GROUPS = NUM_ROUNDS / ROUNDS_PER_CYCLE;
  localparam int RC_W       = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(NUM_GROUPS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ROUNDS - 1);
  localparam logic [IDX_W-1:0] IDX_STEP = IDX_W'(ROUNDS_PER_CYCLE);

  localparam int E_TBL [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_TBL [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // Each box is 64 nibbles, row-major (row*16+col), first entry in the top nibble.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B};

  function automatic logic [31:0] f_des(input logic [31:0] r, input logic [47:0] k);
    logic [47:0]  x;
    logic [31:0]  s;
    logic [31:0]  res;
    logic [255:0] box;
    logic [5:0]   six;
    logic [5:0]   addr;
    x   = '0;
    s   = '0;
    res = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_TBL[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      six  = x[47-6*b -: 6];
      addr = {six[5], six[0], six[4:1]};
      box  = SBOX[b] << (4 * addr);
      s[31-4*b -: 4] = box[255:252];
    end
    for (int i = 0; i < 32; i++) res[31-i] = s[32-P_TBL[i]];
    return res;
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [31:0]      l_q, l_d, r_q, r_d;
  logic             dec_q, dec_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [63:0]      out_block_q, out_block_d;
  logic [IDX_W-1:0] grp_idx;
  logic [31:0]      l_chain [ROUNDS_PER_CYCLE+1];
  logic [31:0]      r_chain [ROUNDS_PER_CYCLE+1];

  always_comb begin
    l_chain[0] = l_q;
    r_chain[0] = r_q;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      l_chain[j+1] = r_chain[j];
      r_chain[j+1] = l_chain[j] ^ f_des(r_chain[j], bus.round_keys[48*j +: 48]);
    end
  end

  // The product stays below NUM_ROUNDS, so IDX_W bits never truncate it.
  assign grp_idx       = IDX_W'(rc_q) * IDX_STEP;
  assign bus.key_idx   = (state_q != S_RUN) ? '0 : (dec_q ? IDX_LAST - grp_idx : grp_idx);
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_block = out_block_q;

  always_comb begin
    state_d     = state_q;
    l_d         = l_q;
    r_d         = r_q;
    dec_d       = dec_q;
    rc_d        = rc_q;
    out_block_d = out_block_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          l_d     = bus.in_block[63:32];
          r_d     = bus.in_block[31:0];
          dec_d   = bus.in_decrypt;
          rc_d    = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        l_d  = l_chain[ROUNDS_PER_CYCLE];
        r_d  = r_chain[ROUNDS_PER_CYCLE];
        rc_d = rc_q + 1'b1;
        if (rc_q == RC_LAST) begin
          out_block_d = {r_chain[ROUNDS_PER_CYCLE], l_chain[ROUNDS_PER_CYCLE]};
          rc_d        = '0;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef FEISTEL_ABORT_EN
    if (bus.abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      rc_d    = '0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      l_q         <= '0;
      r_q         <= '0;
      dec_q       <= 1'b0;
      rc_q        <= '0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      l_q         <= l_d;
      r_q         <= r_d;
      dec_q       <= dec_d;
      rc_q        <= rc_d;
      out_block_q <= out_block_d;
    end
  end
endmodule

// File: tb/tb_feistel_round_engine.sv
// Bench for feistel_round_engine: 1-, 4- and 16-round-per-cycle builds run in lockstep
// against a DES reference model; exercises abort when FEISTEL_ABORT_EN is defined.
`timescale 1ns/1ps
module tb_feistel_round_engine;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_decrypt, out_ready, cur_dec;
  logic [63:0] in_block;
`ifdef FEISTEL_ABORT_EN
  logic        abort;
`endif
  logic [15:0][47:0] ks;

  localparam int RPC [3] = '{1, 4, 16};

  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18, 10, 2, 59, 51, 43, 35, 27, 19, 11, 3,
    60, 52, 44, 36, 63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22, 14, 6, 61, 53, 45, 37,
    29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10, 23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48, 44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  // One entry per S-box row (box*4 + row), column 0 in the top nibble.
  localparam logic [63:0] S_T [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  function automatic logic [15:0][47:0] key_sched(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [15:0][47:0] res;
    res = '0;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) res[r][47-i] = cd[56-PC2_T[i]];
    end
    return res;
  endfunction

  function automatic logic [31:0] f_ref(input logic [31:0] r, input logic [47:0] k);
    logic [47:0] x;
    logic [31:0] s, y;
    logic [1:0]  rw;
    logic [3:0]  cl;
    logic [63:0] w;
    s = '0;
    y = '0;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int b = 0; b < 8; b++) begin
      rw = {x[47-6*b], x[42-6*b]};
      cl = x[46-6*b -: 4];
      w  = S_T[b*4 + int'(rw)];
      s[31-4*b -: 4] = w[63-4*int'(cl) -: 4];
    end
    for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic dec);
    logic [31:0] l, r, t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ f_ref(r, ks[dec ? 15 - i : i]);
      l = t;
    end
    return {r, l};
  endfunction

  // Key source: lane j gets the key j steps further along the active key order.
  function automatic logic [767:0] lane_keys(input logic [3:0] idx, input logic dec,
                                             input logic [15:0][47:0] k);
    logic [767:0] v;
    logic [3:0]   n;
    for (int j = 0; j < 16; j++) begin
      n = dec ? idx - 4'(j) : idx + 4'(j);
      v[48*j +: 48] = k[n];
    end
    return v;
  endfunction

  feistel_round_engine_if #(.ROUNDS_PER_CYCLE(1),  .IDX_W(4)) bus1  ();
  feistel_round_engine_if #(.ROUNDS_PER_CYCLE(4),  .IDX_W(4)) bus4  ();
  feistel_round_engine_if #(.ROUNDS_PER_CYCLE(16), .IDX_W(4)) bus16 ();

  feistel_round_engine #(.NUM_ROUNDS(16), .ROUNDS_PER_CYCLE(1), .IDX_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  feistel_round_engine #(.NUM_ROUNDS(16), .ROUNDS_PER_CYCLE(4), .IDX_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));
  feistel_round_engine #(.NUM_ROUNDS(16), .ROUNDS_PER_CYCLE(16), .IDX_W(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(bus16.slave));

  assign bus1.in_valid    = in_valid;
  assign bus1.in_block    = in_block;
  assign bus1.in_decrypt  = in_decrypt;
  assign bus1.out_ready   = out_ready;
  assign bus1.round_keys  = 48'(lane_keys(bus1.key_idx, cur_dec, ks));
  assign bus4.in_valid    = in_valid;
  assign bus4.in_block    = in_block;
  assign bus4.in_decrypt  = in_decrypt;
  assign bus4.out_ready   = out_ready;
  assign bus4.round_keys  = 192'(lane_keys(bus4.key_idx, cur_dec, ks));
  assign bus16.in_valid   = in_valid;
  assign bus16.in_block   = in_block;
  assign bus16.in_decrypt = in_decrypt;
  assign bus16.out_ready  = out_ready;
  assign bus16.round_keys = lane_keys(bus16.key_idx, cur_dec, ks);
`ifdef FEISTEL_ABORT_EN
  assign bus1.abort  = abort;
  assign bus4.abort  = abort;
  assign bus16.abort = abort;
`endif

  logic        ir [3];
  logic        ov [3];
  logic [3:0]  kx [3];
  logic [63:0] ob [3];
  assign ir[0] = bus1.in_ready;   assign ir[1] = bus4.in_ready;   assign ir[2] = bus16.in_ready;
  assign ov[0] = bus1.out_valid;  assign ov[1] = bus4.out_valid;  assign ov[2] = bus16.out_valid;
  assign kx[0] = bus1.key_idx;    assign kx[1] = bus4.key_idx;    assign kx[2] = bus16.key_idx;
  assign ob[0] = bus1.out_block;  assign ob[1] = bus4.out_block;  assign ob[2] = bus16.out_block;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshake a block, track each build to out_valid, hold it, then release it.
  task automatic run_block(input logic [63:0] blk, input logic dec, input logic [63:0] exp,
                           input int hold);
    bit done [3];
    int ndone;
    int lat;
    ndone = 0;
    for (int d = 0; d < 3; d++) done[d] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) chk($sformatf("in_ready_idle_r%0d", RPC[d]), 64'(ir[d]), 64'd1);
    in_valid   = 1'b1;
    in_block   = blk;
    in_decrypt = dec;
    cur_dec    = dec;
    @(negedge clk);
    in_valid   = 1'b0;
    in_block   = {$urandom, $urandom};
    in_decrypt = ~dec;
    for (int k = 0; k < 40 && ndone < 3; k++) begin
      for (int d = 0; d < 3; d++) begin
        if (!done[d]) begin
          lat = 16 / RPC[d];
          if (ov[d]) begin
            done[d] = 1'b1;
            ndone++;
            chk($sformatf("latency_r%0d", RPC[d]), 64'(k), 64'(lat));
            chk($sformatf("out_block_r%0d", RPC[d]), ob[d], exp);
          end else if (k < lat) begin
            chk($sformatf("key_idx_r%0d_c%0d", RPC[d], k), 64'(kx[d]),
                64'(dec ? 15 - k * RPC[d] : k * RPC[d]));
            chk($sformatf("in_ready_run_r%0d", RPC[d]), 64'(ir[d]), 64'd0);
          end
        end
      end
      if (ndone < 3) @(negedge clk);
    end
    if (ndone < 3) chk("out_valid_timeout", 64'(ndone), 64'd3);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_block = {$urandom, $urandom};
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("hold_block_r%0d", RPC[d]), ob[d], exp);
        chk($sformatf("hold_valid_r%0d", RPC[d]), 64'(ov[d]), 64'd1);
        chk($sformatf("hold_in_ready_r%0d", RPC[d]), 64'(ir[d]), 64'd0);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("release_in_ready_r%0d", RPC[d]), 64'(ir[d]), 64'd1);
      chk($sformatf("release_valid_r%0d", RPC[d]), 64'(ov[d]), 64'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] blk;
    logic        dec;
    ks         = key_sched(64'h133457799BBCDFF1);
    rst_n      = 1'b0;
    in_valid   = 1'b1;
    in_block   = 64'hCC00CCFFF0AAF0AA;
    in_decrypt = 1'b0;
    cur_dec    = 1'b0;
    out_ready  = 1'b0;
`ifdef FEISTEL_ABORT_EN
    abort      = 1'b0;
`endif
    repeat (3) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("rst_in_ready_r%0d", RPC[d]), 64'(ir[d]), 64'd1);
        chk($sformatf("rst_valid_r%0d", RPC[d]), 64'(ov[d]), 64'd0);
        chk($sformatf("rst_block_r%0d", RPC[d]), ob[d], 64'd0);
        chk($sformatf("rst_key_idx_r%0d", RPC[d]), 64'(kx[d]), 64'd0);
      end
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("post_rst_idle_r%0d", RPC[d]), 64'(ir[d]), 64'd1);
      chk($sformatf("post_rst_valid_r%0d", RPC[d]), 64'(ov[d]), 64'd0);
    end

    run_block(64'hCC00CCFFF0AAF0AA, 1'b0, 64'h0A4CD99543423234, 0);
    run_block(64'h0A4CD99543423234, 1'b1, 64'hCC00CCFFF0AAF0AA, 0);
    blk = {$urandom, $urandom};
    run_block(blk, 1'b0, des_ref(blk, 1'b0), 10);

`ifdef FEISTEL_ABORT_EN
    @(negedge clk);
    in_valid   = 1'b1;
    in_block   = 64'hCC00CCFFF0AAF0AA;
    in_decrypt = 1'b0;
    cur_dec    = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      chk("abort_pre_valid_r1", 64'(ov[0]), 64'd0);
      @(negedge clk);
    end
    chk("abort_round_idx_r1", 64'(kx[0]), 64'd7);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("abort_in_ready_r%0d", RPC[d]), 64'(ir[d]), 64'd1);
      chk($sformatf("abort_valid_r%0d", RPC[d]), 64'(ov[d]), 64'd0);
    end
    repeat (3) begin
      @(negedge clk);
      chk("abort_stays_idle_r1", 64'(ov[0]), 64'd0);
    end
    run_block(64'hCC00CCFFF0AAF0AA, 1'b0, 64'h0A4CD99543423234, 0);
`endif

    for (int t = 0; t < 8; t++) begin
      blk = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      run_block(blk, dec, des_ref(blk, dec), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
